// File: rtl/switch_bounce_gen.sv
// switch_bounce_gen: mechanical-switch emulator for the debounce path.
// On a start command it toggles raw_sig_o for a requested number of slots,
// forces the requested settled level, holds it for HOLD_CYCLES cycles and
// then pulses done_o.
// Optional feature: define BOUNCE_RANDOM_GAP_EN to space the toggles by a
// pseudo-random 1..4 cycle gap taken from an 8-bit LFSR; otherwise toggles
// occur on consecutive cycles and no LFSR is built.
module switch_bounce_gen #(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter int unsigned BOUNCE_W    = 4,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                level_i,
  input  logic [BOUNCE_W-1:0] bounces_i,
  output logic                raw_sig_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  // Hold counter start value: H-1 down to 0, one extra cycle for the done edge.
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  state_e              state_q, state_d;
  logic                raw_q, raw_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                level_q, level_d;
  logic                entry_q, entry_d;   // first HOLD cycle still to be applied
  logic [BOUNCE_W-1:0] togg_q, togg_d;     // toggles still to emit
  logic [15:0]         hold_q, hold_d;
  logic                toggle_slot;        // current BOUNCE cycle emits a toggle

`ifdef BOUNCE_RANDOM_GAP_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [1:0] gap_q, gap_d;                // extra wait cycles before next toggle
  logic       lfsr_fb;

  // Fibonacci feedback for x^8+x^6+x^5+x^4+1.
  assign lfsr_fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign toggle_slot = (gap_q == 2'd0);

  // Gap countdown; the LFSR steps once per emitted toggle and seeds the next gap.
  always_comb begin
    lfsr_d = lfsr_q;
    gap_d  = gap_q;
    if (state_q == ST_IDLE && start_i) begin
      gap_d = lfsr_q[1:0];
    end else if (state_q == ST_BOUNCE) begin
      if (toggle_slot) begin
        lfsr_d = {lfsr_q[6:0], lfsr_fb};
        gap_d  = {lfsr_q[0], lfsr_fb};
      end else begin
        gap_d = gap_q - 2'd1;
      end
    end
  end

  // Gap state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
      gap_q  <= 2'd0;
    end else begin
      lfsr_q <= lfsr_d;
      gap_q  <= gap_d;
    end
  end
`else
  assign toggle_slot = 1'b1;
`endif

  // Sequencer: next state, registered-output values and counters.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    raw_d   = raw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    level_d = level_q;
    entry_d = entry_q;
    togg_d  = togg_q;
    hold_d  = hold_q;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start_i) begin
          level_d = level_i;
          togg_d  = bounces_i;
          if (bounces_i != '0) begin
            state_d = ST_BOUNCE;
          end else begin
            state_d = ST_HOLD;
            entry_d = 1'b1;
          end
        end
      end

      ST_BOUNCE: begin
        busy_d = 1'b1;
        if (toggle_slot) begin
          raw_d  = ~raw_q;
          togg_d = togg_q - BOUNCE_W'(1);
          if (togg_q == BOUNCE_W'(1)) begin
            state_d = ST_HOLD;
            entry_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (entry_q) begin
          // Level is forced regardless of toggle parity; an extra edge is fine.
          raw_d   = level_q;
          busy_d  = 1'b1;
          hold_d  = HOLD_LAST;
          entry_d = 1'b0;
        end else if (hold_q == 16'd0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any sequence without done_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      raw_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      level_q <= 1'b0;
      entry_q <= 1'b0;
      togg_q  <= '0;
      hold_q  <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      raw_q   <= raw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      level_q <= level_d;
      entry_q <= entry_d;
      togg_q  <= togg_d;
      hold_q  <= hold_d;
    end
  end

  assign raw_sig_o = raw_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Testbench for switch_bounce_gen (fixed-gap build, HOLD_CYCLES = 10).
// Expected outputs come from a cycle-indexed reference model: for a start
// accepted at edge k with N toggles and hold H, the value after edge k+j is
// derived directly from the documented timing rules.
`timescale 1ns/1ps
module tb_switch_bounce_gen;

  localparam int H  = 10;
  localparam int BW = 4;

  logic          clk_i     = 1'b0;
  logic          rst_ni    = 1'b0;
  logic          start_i   = 1'b0;
  logic          level_i   = 1'b0;
  logic [BW-1:0] bounces_i = '0;
  logic          raw_sig_o;
  logic          busy_o;
  logic          done_o;

  int   n_cmp     = 0;
  int   n_err     = 0;
  logic model_raw = 1'b0;   // level the line rests at while idle

  always #5 clk_i = ~clk_i;

  switch_bounce_gen #(
    .HOLD_CYCLES (H),
    .BOUNCE_W    (BW),
    .LFSR_SEED   (8'hA5)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .level_i   (level_i),
    .bounces_i (bounces_i),
    .raw_sig_o (raw_sig_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Idle cycles: line rests at the model level, no busy, no done.
  task automatic idle_cycles(input int c, input string tag);
    logic [2:0] got, exp;
    for (int i = 0; i < c; i++) begin
      @(negedge clk_i);
      got = {raw_sig_o, busy_o, done_o};
      exp = {model_raw, 1'b0, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s idle%0d {raw,busy,done} got %b expected %b", tag, i, got, exp);
      end
    end
  endtask

  // One full sequence. Entered at a negedge with the DUT idle (or in its done
  // cycle); returns at the negedge of this sequence's done cycle.
  task automatic run_seq(input int n, input logic l, input bit poke, input string tag);
    logic       r0, raw_e, busy_e, done_e;
    logic [2:0] got, exp;
    int         last;
    r0   = model_raw;
    last = n + H + 1;
    start_i   = 1'b1;
    level_i   = l;
    bounces_i = BW'(n);
    @(negedge clk_i);             // edge k has sampled the start
    start_i   = 1'b0;
    level_i   = 1'($urandom);
    bounces_i = BW'($urandom);
    for (int j = 0; j <= last; j++) begin
      if (j > 0) @(negedge clk_i);
      if (j == 0)      raw_e = r0;
      else if (j <= n) raw_e = r0 ^ j[0];
      else             raw_e = l;
      busy_e = (j >= 1) && (j <= n + H);
      done_e = (j == last);
      got = {raw_sig_o, busy_o, done_o};
      exp = {raw_e, busy_e, done_e};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s j=%0d n=%0d {raw,busy,done} got %b expected %b", tag, j, n, got, exp);
      end
      // Stray commands while busy must be ignored; never in the done cycle.
      if (poke && j < last) begin
        start_i   = 1'($urandom);
        level_i   = 1'($urandom);
        bounces_i = BW'($urandom);
      end else begin
        start_i = 1'b0;
      end
    end
    model_raw = l;
  endtask

  task automatic test_reset();
    logic [2:0] got;
    rst_ni  = 1'b0;
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      got = {raw_sig_o, busy_o, done_o};
      n_cmp++;
      if (got !== 3'b000) begin
        n_err++;
        $display("FAIL reset cyc%0d {raw,busy,done} got %b expected 000", i, got);
      end
    end
    rst_ni    = 1'b1;
    model_raw = 1'b0;
    idle_cycles(2, "post_reset");
  endtask

  task automatic test_directed();
    run_seq(10, 1'b1, 1'b0, "burst10_hi");
    idle_cycles(2, "burst10_hi");
    run_seq(6, 1'b0, 1'b0, "burst6_lo");
    idle_cycles(1, "burst6_lo");
    run_seq(0, 1'b1, 1'b0, "zero_bounce");
    idle_cycles(2, "zero_bounce");
    run_seq(15, 1'b0, 1'b0, "max_bounce");
    idle_cycles(1, "max_bounce");
  endtask

  task automatic test_ignore_start();
    run_seq(8, 1'b1, 1'b1, "ignore_start_a");
    idle_cycles(1, "ignore_start_a");
    run_seq(0, 1'b0, 1'b1, "ignore_start_b");
    idle_cycles(1, "ignore_start_b");
  endtask

  task automatic test_back_to_back();
    run_seq(5, 1'b1, 1'b1, "b2b_first");
    run_seq(3, 1'b0, 1'b0, "b2b_second");
    run_seq(0, 1'b1, 1'b1, "b2b_third");
    idle_cycles(2, "b2b_tail");
  endtask

  task automatic test_random();
    int   n;
    logic l;
    bit   p;
    for (int it = 0; it < 16; it++) begin
      n = int'($urandom_range(0, 15));
      l = 1'($urandom);
      p = 1'($urandom);
      run_seq(n, l, p, $sformatf("rand%0d", it));
      idle_cycles(int'($urandom_range(0, 2)), $sformatf("rand%0d", it));
    end
  endtask

  task automatic test_reset_abort();
    logic [2:0] got;
    logic       r0;
    r0 = model_raw;
    start_i   = 1'b1;
    level_i   = 1'b1;
    bounces_i = BW'(10);
    @(posedge clk_i);             // edge k
    #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);  // edge k+4: four toggles emitted
    #1;
    got = {raw_sig_o, busy_o, done_o};
    n_cmp++;
    if (got !== {r0, 2'b10}) begin
      n_err++;
      $display("FAIL abort_pre {raw,busy,done} got %b expected %b", got, {r0, 2'b10});
    end
    rst_ni = 1'b0;
    #1;
    got = {raw_sig_o, busy_o, done_o};
    n_cmp++;
    if (got !== 3'b000) begin
      n_err++;
      $display("FAIL abort_async {raw,busy,done} got %b expected 000", got);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      got = {raw_sig_o, busy_o, done_o};
      n_cmp++;
      if (got !== 3'b000) begin
        n_err++;
        $display("FAIL abort_hold cyc%0d {raw,busy,done} got %b expected 000", i, got);
      end
    end
    rst_ni    = 1'b1;
    model_raw = 1'b0;
    idle_cycles(3, "abort_release");
    run_seq(10, 1'b1, 1'b0, "after_abort");
    idle_cycles(1, "after_abort");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
